// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner
//   Scans a 4x4 matrix keypad one column at a time. Each column is driven
//   for SCAN_COUNT clocks. The rows are read back through a 2-flop
//   synchronizer. Each full sweep is classified as no key, exactly one key,
//   or several keys. A press or a release is accepted only after
//   DEBOUNCE_SCANS identical sweeps in a row. Each accepted press gives one
//   hex key code.
//
//   Parameters
//     SCAN_COUNT      clocks each column stays driven (must be >= 3 so the
//                     synchronized rows settle before the sample point)
//     DEBOUNCE_SCANS  identical sweeps needed to accept a press/release, 1..15
//
//   Ports
//     CLK        in   system clock
//     RST_N      in   asynchronous active-low reset
//     ROW[3:0]   in   keypad rows, active-low, asynchronous to CLK
//     COL[3:0]   out  column drive, active-low one-hot (1110,1101,1011,0111)
//     KEY_CODE   out  hex code of last accepted key, held until next accept
//     KEY_VALID  out  one-cycle strobe when KEY_CODE takes a new accept
//     KEY_HELD   out  high while the accepted key is considered down
module keypad_scanner #(
    parameter int SCAN_COUNT     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    output logic       KEY_HELD
);

    localparam int               CNT_W    = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_COUNT - 1);
    localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEB_PRESS,
        S_PRESSED,
        S_DEB_REL
    } state_t;

    typedef enum logic [1:0] {
        SW_NONE,
        SW_SINGLE,
        SW_MULTI
    } sweep_t;

    // Column c, row r -> hex legend printed on the key.
    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] k;
        k = 4'h0;
        case ({c, r})
            4'h0: k = 4'h1;
            4'h1: k = 4'h4;
            4'h2: k = 4'h7;
            4'h3: k = 4'h0;
            4'h4: k = 4'h2;
            4'h5: k = 4'h5;
            4'h6: k = 4'h8;
            4'h7: k = 4'hF;
            4'h8: k = 4'h3;
            4'h9: k = 4'h6;
            4'hA: k = 4'h9;
            4'hB: k = 4'hE;
            4'hC: k = 4'hA;
            4'hD: k = 4'hB;
            4'hE: k = 4'hC;
            4'hF: k = 4'hD;
        endcase
        return k;
    endfunction

    // ------------------------------------------------------------------
    // Row synchronizer. It resets to "all released".
    // ------------------------------------------------------------------
    logic [3:0] row_meta_q, row_sync_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= ROW;
            row_sync_q <= row_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Column scan. The snapshots for columns 0..2 are stored. Column 3 is
    // never stored: the sweep is evaluated on the cycle column 3 is
    // sampled, so its rows come straight from the synchronizer.
    // A cleared snapshot reads as all rows high, which means no key.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] scan_cnt_q;
    logic [1:0]       col_idx_q;
    logic [3:0]       col_q;
    logic [11:0]      snap_q;
    logic             scan_tick;

    assign scan_tick = (scan_cnt_q == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scan_cnt_q <= '0;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            snap_q     <= 12'hFFF;
        end else if (scan_tick) begin
            scan_cnt_q <= '0;
            col_idx_q  <= col_idx_q + 2'd1;
            col_q      <= {col_q[2:0], col_q[3]};
            case (col_idx_q)
                2'd0:    snap_q[3:0]  <= row_sync_q;
                2'd1:    snap_q[7:4]  <= row_sync_q;
                2'd2:    snap_q[11:8] <= row_sync_q;
                default: ;
            endcase
        end else begin
            scan_cnt_q <= scan_cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sweep classification. Bit c*4+r of the pressed vector is set when
    // row r was low while column c was driven. The hit count saturates at
    // 2, because the only thing that matters is none / one / more.
    // ------------------------------------------------------------------
    logic [15:0] pressed;
    logic [1:0]  hits;
    logic [3:0]  hit_key;
    sweep_t      sweep_kind_d;
    logic        sweep_end;

    assign sweep_end = scan_tick && (col_idx_q == 2'd3);

    always_comb begin
        pressed = ~{row_sync_q, snap_q};
        hits    = 2'd0;
        hit_key = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pressed[i]) begin
                if (hits != 2'd2) begin
                    hits = hits + 2'd1;
                end
                hit_key = key_map(2'(i >> 2), 2'(i & 3));
            end
        end
        if (hits == 2'd0) begin
            sweep_kind_d = SW_NONE;
        end else if (hits == 2'd1) begin
            sweep_kind_d = SW_SINGLE;
        end else begin
            sweep_kind_d = SW_MULTI;
        end
    end

    logic       sweep_vld_q;
    sweep_t     sweep_kind_q;
    logic [3:0] sweep_key_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sweep_vld_q  <= 1'b0;
            sweep_kind_q <= SW_NONE;
            sweep_key_q  <= 4'h0;
        end else begin
            sweep_vld_q <= sweep_end;
            if (sweep_end) begin
                sweep_kind_q <= sweep_kind_d;
                sweep_key_q  <= hit_key;
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM. It steps once per registered sweep result.
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       held_q, held_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cand_q  <= 4'h0;
            cnt_q   <= 4'd0;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;

        if (sweep_vld_q) begin
            case (state_q)
                S_IDLE: begin
                    if (sweep_kind_q == SW_SINGLE) begin
                        cand_d = sweep_key_q;
                        cnt_d  = 4'd1;
                        if (DEB_N == 4'd1) begin
                            state_d = S_PRESSED;
                            code_d  = sweep_key_q;
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_DEB_PRESS;
                        end
                    end
                end
                S_DEB_PRESS: begin
                    if (sweep_kind_q == SW_SINGLE) begin
                        if (sweep_key_q == cand_q) begin
                            cnt_d = cnt_q + 4'd1;
                            if (cnt_q + 4'd1 >= DEB_N) begin
                                state_d = S_PRESSED;
                                code_d  = cand_q;
                                valid_d = 1'b1;
                            end
                        end else begin
                            // A different single key restarts the count.
                            cand_d = sweep_key_q;
                            cnt_d  = 4'd1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    // Only a clean release leaves PRESSED. Other keys are
                    // ignored, so there is no repeat and no roll-over.
                    if (sweep_kind_q == SW_NONE) begin
                        cnt_d   = 4'd1;
                        state_d = (DEB_N == 4'd1) ? S_IDLE : S_DEB_REL;
                    end
                end
                S_DEB_REL: begin
                    if (sweep_kind_q == SW_NONE) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 >= DEB_N) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_PRESSED;
                    end
                end
            endcase
        end

        held_d = (state_d == S_PRESSED) || (state_d == S_DEB_REL);
    end

    assign COL       = col_q;
    assign KEY_CODE  = code_q;
    assign KEY_VALID = valid_q;
    assign KEY_HELD  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Directed bench for keypad_scanner with SCAN_COUNT=4, DEBOUNCE_SCANS=2.
// One sweep is 16 clocks. The keypad is modelled as a set of held keys.
// Each key pulls its row low while its column is driven.
module tb_keypad_scanner;

    logic       CLK;
    logic       RST_N;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] KEY_CODE;
    logic       KEY_VALID;
    logic       KEY_HELD;

    logic [15:0] keys;      // bit k set = key with hex legend k is held down

    int n_tests;
    int n_fail;
    int pulses;
    int first_at;
    int held_cnt;
    int drop_at;
    int total;

    keypad_scanner #(
        .SCAN_COUNT     (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ROW       (ROW),
        .COL       (COL),
        .KEY_CODE  (KEY_CODE),
        .KEY_VALID (KEY_VALID),
        .KEY_HELD  (KEY_HELD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [3:0] code_at(input int c, input int r);
        logic [3:0] k;
        k = 4'h0;
        case (c * 4 + r)
            0:  k = 4'h1;
            1:  k = 4'h4;
            2:  k = 4'h7;
            3:  k = 4'h0;
            4:  k = 4'h2;
            5:  k = 4'h5;
            6:  k = 4'h8;
            7:  k = 4'hF;
            8:  k = 4'h3;
            9:  k = 4'h6;
            10: k = 4'h9;
            11: k = 4'hE;
            12: k = 4'hA;
            13: k = 4'hB;
            14: k = 4'hC;
            15: k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    always_comb begin
        ROW = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (COL[c] == 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[code_at(c, r)]) begin
                        ROW[r] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Run n sweeps from a sweep boundary. Samples are taken 1 ns after each
    // rising edge, and edge i counts from 1. The task records the KEY_VALID
    // pulses, the first pulse edge, the number of KEY_HELD-high samples and
    // the first KEY_HELD-low edge.
    task automatic run_sweeps(input int n);
        pulses   = 0;
        first_at = -1;
        held_cnt = 0;
        drop_at  = -1;
        for (int i = 1; i <= n * 16; i++) begin
            @(posedge CLK);
            #1;
            if (KEY_VALID === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
            if (KEY_HELD === 1'b1) begin
                held_cnt++;
            end else if (drop_at < 0) begin
                drop_at = i;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        n_tests = 0;
        n_fail  = 0;
        total   = 0;
        keys    = 16'h0000;
        RST_N   = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_col",   COL,       4'b1110);
        check("rst_code",  KEY_CODE,  4'h0);
        check("rst_valid", KEY_VALID, 1'b0);
        check("rst_held",  KEY_HELD,  1'b0);

        // Idle scan: COL walks 1110,1101,1011,0111 every 4 clocks and wraps
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(posedge CLK);
            #1;
            if (i % 4 == 2) begin
                exp_col = 4'b1111 ^ (4'b0001 << ((i / 4) % 4));
                check($sformatf("col_i%0d", i), COL, exp_col);
            end
        end
        run_sweeps(8);
        check("idle_valid", pulses,   0);
        check("idle_held",  held_cnt, 0);
        check("idle_code",  KEY_CODE, 4'h0);

        // Key 5 held for 6 sweeps: one pulse at the end of sweep 2, +1 clock
        keys = 16'h0001 << 5;
        run_sweeps(6);
        check("k5_pulses", pulses,    1);
        check("k5_at",     first_at,  33);
        check("k5_code",   KEY_CODE,  4'h5);
        check("k5_heldn",  held_cnt,  64);
        check("k5_held",   KEY_HELD,  1'b1);
        keys = 16'h0000;
        run_sweeps(3);
        check("k5_rel_drop",  drop_at,  33);
        check("k5_rel_pulse", pulses,   0);
        check("k5_rel_code",  KEY_CODE, 4'h5);

        // Key 9 bouncing: one sweep pressed, one released, repeated 5 times
        for (int j = 0; j < 5; j++) begin
            keys = 16'h0001 << 9;
            run_sweeps(1);
            total += pulses;
            keys = 16'h0000;
            run_sweeps(1);
            total += pulses;
        end
        check("k9_pulses", total,    0);
        check("k9_code",   KEY_CODE, 4'h5);
        check("k9_held",   KEY_HELD, 1'b0);

        // Accept 7, release it, then press 1 and D together
        keys = 16'h0001 << 7;
        run_sweeps(3);
        check("k7_pulses", pulses,   1);
        check("k7_code",   KEY_CODE, 4'h7);
        keys = 16'h0000;
        run_sweeps(3);
        keys = (16'h0001 << 1) | (16'h0001 << 13);
        run_sweeps(4);
        check("multi_pulses", pulses,   0);
        check("multi_code",   KEY_CODE, 4'h7);
        check("multi_held",   held_cnt, 0);
        keys = 16'h0000;
        run_sweeps(1);

        // E: press, release (held drops after 2 empty sweeps), press again
        keys = 16'h0001 << 14;
        run_sweeps(3);
        check("kE1_pulses", pulses,   1);
        check("kE1_code",   KEY_CODE, 4'hE);
        keys = 16'h0000;
        run_sweeps(3);
        check("kE1_drop",   drop_at,  33);
        keys = 16'h0001 << 14;
        run_sweeps(3);
        check("kE2_pulses", pulses,   1);
        check("kE2_at",     first_at, 33);
        check("kE2_code",   KEY_CODE, 4'hE);
        // A single empty sweep is a bounce: no release and no second pulse
        keys = 16'h0000;
        run_sweeps(1);
        check("kE_gap_drop", drop_at, -1);
        keys = 16'h0001 << 14;
        run_sweeps(3);
        check("kE3_pulses", pulses,  0);
        check("kE3_drop",   drop_at, -1);
        keys = 16'h0000;
        run_sweeps(3);

        // Reset asserted while key A is in press debounce
        keys = 16'h0001 << 10;
        run_sweeps(1);
        @(posedge CLK);
        #1;
        check("kA_pre_valid", KEY_VALID, 1'b0);
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("kA_rst_col",   COL,       4'b1110);
        check("kA_rst_code",  KEY_CODE,  4'h0);
        check("kA_rst_valid", KEY_VALID, 1'b0);
        check("kA_rst_held",  KEY_HELD,  1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        run_sweeps(3);
        check("kA_pulses", pulses,   1);
        check("kA_at",     first_at, 33);
        check("kA_code",   KEY_CODE, 4'hA);
        check("kA_held",   KEY_HELD, 1'b1);
        keys = 16'h0000;
        run_sweeps(3);
        check("kA_rel_held", KEY_HELD, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad (Pmod KYPD style) on the input side of the board I/O: drives one column low at a time and reads the four rows back. This is the input-side counterpart of our time-multiplexed 7-segment drive.
- Debounces the result over whole sweeps and emits one hex key code per debounced press.
- KEY_CODE/KEY_VALID feed operand entry for the ALU/display datapath, replacing raw switch inputs.

Parameters:
- SCAN_COUNT, 100000: CLK cycles each column stays driven; 1 ms at 100 MHz, so one sweep is 4 ms.
- DEBOUNCE_SCANS, 4: consecutive identical sweeps needed to accept a press or a release. Legal values are 1..15.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST_N  in  1  reset, asynchronous, active-low.
- ROW  in  4  keypad rows, active-low (external pull-ups), asynchronous to CLK.
- COL  out  4  column drive, active-low one-hot.
- KEY_CODE  out  4  hex code of last accepted key; holds until the next accepted press.
- KEY_VALID  out  1  one-cycle strobe when a new KEY_CODE is accepted.
- KEY_HELD  out  1  level, high while the accepted key is considered down.

Behaviour:
- Reset (RST_N low, async, takes effect immediately):
  - COL=4'b1110, KEY_CODE=0, KEY_VALID=0, KEY_HELD=0.
  - Scan counter, column index, snapshots and debounce count all cleared; FSM in IDLE.
- ROW input: 2-flop synchronizer. ROW must be stable at least 2 cycles before a sample point.
- Column scan:
  - Counter runs 0..SCAN_COUNT-1 and wraps.
  - At count==SCAN_COUNT-1: latch the synchronized ROW as the snapshot for the current column, then advance the column 0->1->2->3->0.
  - COL patterns in order: 1110, 1101, 1011, 0111.
- Key map (column c, row r, r = ROW bit low while column c is driven):
  - c0: r0..r3 = 1, 4, 7, 0
  - c1: r0..r3 = 2, 5, 8, F
  - c2: r0..r3 = 3, 6, 9, E
  - c3: r0..r3 = A, B, C, D
- Sweep result:
  - Evaluated on the cycle column 3 is sampled; the FSM acts on the next cycle.
  - Result is exactly one of: NONE (16 bits released), SINGLE(k) (exactly one bit low), MULTI (two or more low).
- FSM, one step per sweep result; cand is the candidate key, cnt the debounce count:
  - IDLE:
    - SINGLE(k): cand=k, cnt=1, go to DEB_PRESS. If DEBOUNCE_SCANS==1, go directly to PRESSED with an accept.
    - NONE or MULTI: stay.
  - DEB_PRESS:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS, accept and go to PRESSED.
    - SINGLE(k!=cand): cand=k, cnt=1.
    - NONE or MULTI: go to IDLE.
  - PRESSED:
    - NONE: cnt=1, go to DEB_REL. If DEBOUNCE_SCANS==1, go directly to IDLE.
    - SINGLE (any key) or MULTI: stay. No new event until full release; no auto-repeat.
  - DEB_REL:
    - NONE: cnt+1. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
    - Anything else: go back to PRESSED with no new KEY_VALID.
- Accept action: KEY_CODE<=cand and KEY_VALID=1 for exactly one cycle, both registered in the same cycle as the transition into PRESSED.
- KEY_HELD=1 in PRESSED and DEB_REL, 0 otherwise (registered).
- Latency: KEY_VALID rises 1 cycle after the end of the DEBOUNCE_SCANS-th consecutive matching sweep.
- Simultaneous events:
  - MULTI never produces a code.
  - A key change during DEB_PRESS restarts the debounce.
  - A reset during any state discards the pending candidate; no KEY_VALID is emitted for it.

Test Plan (bench parameters SCAN_COUNT=4, DEBOUNCE_SCANS=2; one sweep = 16 cycles):
- Reset, then release RST_N, all ROW=1111 -> COL steps 1110, 1101, 1011, 0111 every 4 cycles and wraps; KEY_VALID/KEY_HELD stay 0 and KEY_CODE=0 for 10 sweeps.
- Hold key 5 (ROW[1] low whenever COL=1101) for 6 sweeps -> exactly one KEY_VALID pulse, with KEY_CODE=5, at the end of sweep 2 +1 cycle; KEY_HELD=1 until release.
- Key 9 bounces (pressed 1 sweep, released 1 sweep, repeated 5 times) -> no KEY_VALID; KEY_CODE unchanged.
- Keys 1 and D pressed together from IDLE for 4 sweeps -> no KEY_VALID; after a prior accept of 7, KEY_CODE stays 7.
- Press E then release -> KEY_HELD falls after 2 empty sweeps. Re-press E -> second KEY_VALID with KEY_CODE=E. A single empty sweep between presses -> no second pulse.
- Assert RST_N low during DEB_PRESS for key A -> outputs go to reset values immediately and COL=1110. After RST_N goes high with A still held, KEY_VALID appears only after 2 full fresh sweeps.
